// File: rtl/eth_tx_frame_builder.sv
// Ethernet II transmit framer: serialises dst/src MAC, optional 802.1Q tag and
// EtherType, then passes the payload through to the MAC. Optional tag: ETH_TX_VLAN_EN.
module eth_tx_frame_builder #(
  parameter int MAX_FRAMES_W = 16
) (
  input  logic                    clk_125mhz,
  input  logic                    rst_n,
  input  logic [47:0]             hdr_dst_mac,
  input  logic [47:0]             hdr_src_mac,
  input  logic [15:0]             hdr_ethertype,
  input  logic [15:0]             hdr_vlan_tci,
  input  logic                    hdr_valid,
  output logic                    hdr_ready,
  input  logic [7:0]              s_axis_tdata,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic                    s_axis_tready,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic [MAX_FRAMES_W-1:0] frame_count
);

  // Handshakes: a beat moves on a rising edge where valid and ready are both
  // high; a source holds valid and data stable until that edge.

`ifdef ETH_TX_VLAN_EN
  localparam int HLEN = 18;
`else
  localparam int HLEN = 14;
`endif
  localparam int         HBITS    = HLEN * 8;
  localparam logic [4:0] LAST_IDX = 5'(HLEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HDR     = 2'd1,
    ST_PAYLOAD = 2'd2
  } state_t;

  state_t                  state;
  logic [4:0]              idx;
  logic [HBITS-1:0]        hdr_q;
  logic [HBITS-1:0]        hdr_in;
  logic [7:0]              hdr_byte_q;
  logic                    hdr_ready_q;
  logic                    busy_q;
  logic [MAX_FRAMES_W-1:0] count_q;
  logic                    tlast_accept;

  // Header bytes packed in wire order, first byte in the top bits.
`ifdef ETH_TX_VLAN_EN
  assign hdr_in = {hdr_dst_mac, hdr_src_mac, 16'h8100, hdr_vlan_tci, hdr_ethertype};
`else
  logic unused_tci;
  assign unused_tci = ^hdr_vlan_tci;
  assign hdr_in     = {hdr_dst_mac, hdr_src_mac, hdr_ethertype};
`endif

  function automatic logic [7:0] byte_at(input logic [HBITS-1:0] v, input logic [4:0] i);
    logic [HBITS-1:0] sh;
    sh = v << {i, 3'b000};
    return sh[HBITS-1 -: 8];
  endfunction

  assign tlast_accept = (state == ST_PAYLOAD) && s_axis_tvalid && s_axis_tlast && m_axis_tready;

  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      hdr_q       <= '0;
      hdr_byte_q  <= '0;
      hdr_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hdr_valid && hdr_ready_q) begin
            hdr_q       <= hdr_in;
            idx         <= '0;
            // First byte comes straight from the ports: hdr_q is not loaded yet.
            hdr_byte_q  <= byte_at(hdr_in, 5'd0);
            hdr_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state       <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (m_axis_tready) begin
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= ST_PAYLOAD;
            end else begin
              idx        <= idx + 5'd1;
              hdr_byte_q <= byte_at(hdr_q, idx + 5'd1);
            end
          end
        end
        ST_PAYLOAD: begin
          if (tlast_accept) begin
            hdr_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          hdr_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  // Counts every completed frame, bad-frame flag or not; wraps naturally.
  always_ff @(posedge clk_125mhz or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (tlast_accept) begin
      count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    m_axis_tdata  = 8'h00;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    s_axis_tready = 1'b0;
    case (state)
      ST_HDR: begin
        m_axis_tdata  = hdr_byte_q;
        m_axis_tvalid = 1'b1;
      end
      ST_PAYLOAD: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
        s_axis_tready = m_axis_tready;
      end
      default: begin
      end
    endcase
  end

  assign hdr_ready   = hdr_ready_q;
  assign busy        = busy_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_eth_tx_frame_builder.sv
// Bench for eth_tx_frame_builder: table of frames plus random frames, compared
// against a byte-list model of the frame; a second instance checks counter wrap.
`timescale 1ns/1ps
module tb_eth_tx_frame_builder;

`ifdef ETH_TX_VLAN_EN
  localparam int HLEN = 18;
`else
  localparam int HLEN = 14;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] hdr_dst_mac, hdr_src_mac;
  logic [15:0] hdr_ethertype, hdr_vlan_tci;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic        m_axis_tready;
  logic        busy;
  logic [15:0] frame_count;

  logic        unused_hdr_ready2, unused_s_tready2, unused_tvalid2, unused_tlast2;
  logic        unused_tuser2, unused_busy2;
  logic [7:0]  unused_tdata2;
  logic [1:0]  frame_count2;

  always #4 clk = ~clk;

  eth_tx_frame_builder #(.MAX_FRAMES_W(16)) dut (
    .clk_125mhz(clk), .rst_n(rst_n),
    .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_ethertype(hdr_ethertype), .hdr_vlan_tci(hdr_vlan_tci),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_tready(m_axis_tready),
    .busy(busy), .frame_count(frame_count)
  );

  eth_tx_frame_builder #(.MAX_FRAMES_W(2)) dut_wrap (
    .clk_125mhz(clk), .rst_n(rst_n),
    .hdr_dst_mac(hdr_dst_mac), .hdr_src_mac(hdr_src_mac),
    .hdr_ethertype(hdr_ethertype), .hdr_vlan_tci(hdr_vlan_tci),
    .hdr_valid(hdr_valid), .hdr_ready(unused_hdr_ready2),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .s_axis_tready(unused_s_tready2),
    .m_axis_tdata(unused_tdata2), .m_axis_tvalid(unused_tvalid2),
    .m_axis_tlast(unused_tlast2), .m_axis_tuser(unused_tuser2),
    .m_axis_tready(m_axis_tready),
    .busy(unused_busy2), .frame_count(frame_count2)
  );

  typedef struct {
    logic [47:0] dst;
    logic [47:0] src;
    logic [15:0] etype;
    logic [15:0] tci;
    int          len;
    int          pmode;     // 0 incrementing, 1 random, 2 constant 0xAA
    bit          bad;
    int          bp;        // 0 ready, 1 toggle 1,0,1,0, 2 random ready and random source gaps
    bit          b2b;       // start in the IDLE cycle right after the previous tlast
    int          exp_beats;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  longint      cyc = 0;
  longint      last_tlast_cyc = 0;
  int          exp_count = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  pay[$];
  vec_t        tbl[5];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference frame: header fields byte by byte, most significant first, then payload.
  task automatic build_expected(input vec_t v);
    exp_q.delete();
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(v.dst >> (8 * i)));
    for (int i = 5; i >= 0; i--) exp_q.push_back(8'(v.src >> (8 * i)));
`ifdef ETH_TX_VLAN_EN
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'(v.tci / 256));
    exp_q.push_back(8'(v.tci % 256));
`endif
    exp_q.push_back(8'(v.etype / 256));
    exp_q.push_back(8'(v.etype % 256));
    for (int i = 0; i < v.len; i++) exp_q.push_back(pay[i]);
  endtask

  task automatic fill_payload(input int len, input int pmode);
    pay.delete();
    for (int i = 0; i < len; i++) begin
      if (pmode == 0)      pay.push_back(8'(i));
      else if (pmode == 2) pay.push_back(8'hAA);
      else                 pay.push_back(8'($urandom));
    end
  endtask

  task automatic check_counts();
    check("frame_count", frame_count, 64'(exp_count % 65536));
    check("frame_count_w2", frame_count2, 64'(exp_count % 4));
  endtask

  task automatic idle_cycle(input bit present);
    @(negedge clk);
    cyc++;
    hdr_valid     = 1'b0;
    s_axis_tvalid = present;
    s_axis_tlast  = present;
    s_axis_tuser  = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check("idle_tvalid", m_axis_tvalid, 0);
    check("idle_tlast", m_axis_tlast, 0);
    check("idle_s_tready", s_axis_tready, 0);
    check("idle_hdr_ready", hdr_ready, 1);
    check("idle_busy", busy, 0);
    check_counts();
  endtask

  task automatic send_frame(input vec_t v, input int abort_at);
    int     ptr, got_n, tlast_n, tuser_n, tlast_pos, tuser_pos, budget, total;
    bit     pend, accepted, stall_prev, done;
    logic [7:0] prev_data, e, g;
    longint acc_cyc, first_cyc, tlast_cyc;
    ptr = 0; got_n = 0; tlast_n = 0; tuser_n = 0; tlast_pos = -1; tuser_pos = -1; budget = 0;
    pend = 0; accepted = 0; stall_prev = 0; done = 0; prev_data = 8'h00;
    acc_cyc = 0; first_cyc = -1; tlast_cyc = 0;
    fill_payload(v.len, v.pmode);
    build_expected(v);
    total = exp_q.size();
    got_q.delete();
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (!accepted) begin
        hdr_valid = 1'b1; hdr_dst_mac = v.dst; hdr_src_mac = v.src;
        hdr_ethertype = v.etype; hdr_vlan_tci = v.tci;
      end else begin
        // Headers offered while busy must be ignored.
        hdr_valid = 1'($urandom_range(0, 1));
        hdr_dst_mac = {16'($urandom), $urandom}; hdr_src_mac = {16'($urandom), $urandom};
        hdr_ethertype = 16'($urandom); hdr_vlan_tci = 16'($urandom);
      end
      if (!pend) begin
        if (ptr < v.len) begin
          s_axis_tvalid = (v.bp == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
          s_axis_tdata  = pay[ptr];
          s_axis_tlast  = (ptr == v.len - 1);
          s_axis_tuser  = v.bad && (ptr == v.len - 1);
        end else begin
          s_axis_tvalid = 1'b0;
        end
      end
      case (v.bp)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (budget % 2 == 0);
        default: m_axis_tready = 1'($urandom_range(0, 1));
      endcase
      #1;
      check_counts();
      check("hdr_ready", hdr_ready, 64'(!accepted));
      check("busy", busy, 64'(accepted));
      if (!accepted) check("tvalid_before_hdr", m_axis_tvalid, 0);
      if (accepted && got_n < HLEN) check("hdr_tvalid", m_axis_tvalid, 1);
      if (got_n < HLEN) check("s_tready_held_off", s_axis_tready, 0);
      if (stall_prev) begin
        check("stall_tvalid", m_axis_tvalid, 1);
        check("stall_tdata", m_axis_tdata, 64'(prev_data));
      end
      if (abort_at >= 0 && m_axis_tvalid && got_n == HLEN + abort_at) begin
        rst_n = 1'b0;
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_hdr_ready", hdr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_frame_count_w2", frame_count2, 0);
        check("rst_s_tready", s_axis_tready, 0);
        exp_count = 0;
        return;
      end
      if (!accepted && hdr_valid && hdr_ready) begin
        accepted = 1;
        acc_cyc  = cyc;
      end else if (m_axis_tvalid && first_cyc < 0) begin
        first_cyc = cyc;
      end
      if (m_axis_tvalid && m_axis_tready) begin
        got_q.push_back(m_axis_tdata);
        if (m_axis_tlast) begin tlast_n++; tlast_pos = got_n; end
        if (m_axis_tuser) begin tuser_n++; tuser_pos = got_n; end
        got_n++;
      end
      stall_prev = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      if (s_axis_tvalid && s_axis_tready) begin
        pend = 0;
        ptr++;
        if (s_axis_tlast) begin done = 1; tlast_cyc = cyc; end
      end else begin
        pend = s_axis_tvalid;
      end
      budget++;
      if (budget > 3000) begin
        errors++;
        $display("FAIL timeout: frame did not complete, got %0d beats of %0d", got_n, total);
        done = 1;
      end
    end
    hdr_valid = 1'b0;
    exp_count++;
    check("first_byte_latency", 64'(first_cyc - acc_cyc), 1);
    if (v.b2b) check("b2b_gap", 64'(first_cyc - last_tlast_cyc), 2);
    if (v.bp == 0) check("no_bubble_span", 64'(tlast_cyc - first_cyc + 1), 64'(total));
    check("beat_count", got_n, 64'(v.exp_beats));
    check("tlast_count", tlast_n, 1);
    check("tlast_pos", 64'(tlast_pos), 64'(total - 1));
    check("tuser_count", tuser_n, 64'(v.bad));
    if (v.bad) check("tuser_pos", 64'(tuser_pos), 64'(total - 1));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      check("frame_byte", g, e);
    end
    last_tlast_cyc = tlast_cyc;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    tbl[0] = '{48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0000, 46, 0, 1'b0, 0, 1'b0, HLEN + 46};
    tbl[1] = '{48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800, 16'h0000, 46, 0, 1'b0, 1, 1'b0, HLEN + 46};
    tbl[2] = '{48'h0011_2233_4455, 48'h0266_7788_99AA, 16'h86DD, 16'h0064, 1,  2, 1'b0, 0, 1'b0, HLEN + 1};
    tbl[3] = '{48'hA1B2_C3D4_E5F6, 48'h0203_0405_0607, 16'h0806, 16'h2005, 10, 1, 1'b1, 2, 1'b0, HLEN + 10};
    tbl[4] = '{48'h1234_5678_9ABC, 48'h0200_0000_0002, 16'h88B5, 16'hE00A, 5,  1, 1'b0, 0, 1'b1, HLEN + 5};

    // Reset with junk on every input: outputs must show their reset values.
    rst_n = 1'b0; hdr_valid = 1'b1; hdr_dst_mac = 48'h1; hdr_src_mac = 48'h2;
    hdr_ethertype = 16'h3; hdr_vlan_tci = 16'h4;
    s_axis_tvalid = 1'b1; s_axis_tlast = 1'b1; s_axis_tuser = 1'b1; s_axis_tdata = 8'h5A;
    m_axis_tready = 1'b1;
    @(negedge clk);
    #1;
    check("reset_hdr_ready", hdr_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_frame_count", frame_count, 0);
    check("reset_tvalid", m_axis_tvalid, 0);
    check("reset_tlast", m_axis_tlast, 0);
    check("reset_tuser", m_axis_tuser, 0);
    check("reset_tdata", m_axis_tdata, 0);
    check("reset_s_tready", s_axis_tready, 0);
    @(negedge clk);
    hdr_valid = 1'b0;
    rst_n = 1'b1;
    idle_cycle(1'b1);
    idle_cycle(1'b1);

    for (int i = 0; i < 5; i++) begin
      if (!tbl[i].b2b) idle_cycle(1'b0);
      send_frame(tbl[i], -1);
    end

    for (int i = 0; i < 8; i++) begin
      v.dst = {16'($urandom), $urandom}; v.src = {16'($urandom), $urandom};
      v.etype = 16'($urandom); v.tci = 16'($urandom);
      v.len = $urandom_range(1, 20); v.pmode = 1;
      v.bad = 1'($urandom_range(0, 1)); v.bp = $urandom_range(0, 2);
      v.b2b = 1'($urandom_range(0, 1)); v.exp_beats = HLEN + v.len;
      if (!v.b2b) repeat ($urandom_range(1, 3)) idle_cycle(1'($urandom_range(0, 1)));
      send_frame(v, -1);
    end

    // Reset while payload byte 5 is on the bus, then a clean frame.
    idle_cycle(1'b0);
    v = tbl[0]; v.len = 12; v.exp_beats = HLEN + 12;
    send_frame(v, 5);
    @(negedge clk);
    hdr_valid = 1'b0; s_axis_tvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycle(1'b0);
    v = tbl[3]; v.bp = 0;
    send_frame(v, -1);
    idle_cycle(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_builder.md
# eth_tx_frame_builder

Transmit-side framer that builds an Ethernet II frame from a header command and a byte-wide payload stream, and drives the 8-bit AXI-Stream TX input of the 1G RGMII MAC. It is the transmit counterpart of the RX parser path. It serialises destination MAC, source MAC, optional 802.1Q tag and EtherType, then passes the payload through until `tlast`. Preamble, SFD, padding and FCS remain the MAC's job.

## Interface
- `MAX_FRAMES_W`, 16: width of the transmitted-frame counter.
- `clk_125mhz`  in  1  sole clock; all logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `hdr_dst_mac`  in  48  destination MAC; byte [47:40] is sent first.
- `hdr_src_mac`  in  48  source MAC; byte [47:40] is sent first.
- `hdr_ethertype`  in  16  EtherType; byte [15:8] is sent first.
- `hdr_vlan_tci`  in  16  802.1Q TCI; used only when `ETH_TX_VLAN_EN` is defined, otherwise ignored.
- `hdr_valid` / `hdr_ready`  in/out  1  header command handshake.
- `s_axis_tdata`  in  8  payload byte.
- `s_axis_tvalid`, `s_axis_tlast`, `s_axis_tuser`  in  1  payload stream; `tuser` = bad-frame flag.
- `s_axis_tready`  out  1  payload ready.
- `m_axis_tdata`  out  8  byte to the MAC `tx_axis_tdata`.
- `m_axis_tvalid`, `m_axis_tlast`, `m_axis_tuser`  out  1  stream to the MAC.
- `m_axis_tready`  in  1  MAC ready.
- `busy`  out  1  high from header accept until the payload `tlast` beat is accepted.
- `frame_count`  out  MAX_FRAMES_W  frames completed; wraps.

## Operation
- States:
  - IDLE → HDR on `hdr_valid && hdr_ready`.
  - HDR → PAYLOAD when the last header byte is accepted.
  - PAYLOAD → IDLE when a `tlast` beat is accepted.
- IDLE:
  - `hdr_ready`=1; all four header fields are latched into a header register on accept.
  - `m_axis_tvalid`=0, `s_axis_tready`=0.
- HDR:
  - A 5-bit byte index counts 0..HLEN-1, with HLEN=14 (18 with VLAN).
  - `m_axis_tvalid`=1 and `m_axis_tdata` = the header byte at the index.
  - The index advances only on `m_axis_tready`; `tdata` is held stable while stalled.
  - `m_axis_tlast`=0, `m_axis_tuser`=0, `s_axis_tready`=0.
- Header byte order: dst[47:0] MSB-first, src[47:0] MSB-first, then 0x81, 0x00, TCI[15:8], TCI[7:0] if VLAN, then ethertype[15:8], ethertype[7:0].
- PAYLOAD: pure pass-through, with no storage.
  - `m_axis_tdata`/`tvalid`/`tlast`/`tuser` = the `s_axis_*` signals.
  - `s_axis_tready` = `m_axis_tready`.
- On the accepted `tlast` beat: `frame_count` += 1, wrapping from all-ones to 0. This happens even when `tuser`=1.
- `hdr_valid` while not in IDLE is ignored; `hdr_ready`=0 during HDR and PAYLOAD.
- Payload beats presented while in IDLE or HDR are held off (`s_axis_tready`=0); none are dropped.
- Payload of 0 bytes is not supported. The source must supply at least one beat carrying `tlast`.
- Reset (asynchronous, any state):
  - State → IDLE; index, header register and `frame_count` → 0.
  - A frame in flight is truncated without `tlast`. Recovering the MAC is the system's responsibility.

## Timing
- Reset values:
  - `hdr_ready`=1, `busy`=0, `frame_count`=0.
  - `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tuser`=0, `m_axis_tdata`=0.
  - `s_axis_tready`=0.
- Header accepted at edge N: first dst byte is valid in the cycle after edge N (registered, 1-cycle latency).
- With `m_axis_tready` held at 1:
  - 14 consecutive header beats (18 with VLAN).
  - The first payload beat is passed in the very next cycle, with no bubble.
- Back-to-back frames: one IDLE cycle minimum between the `tlast` beat and the next header's first byte. Header accept occurs in that IDLE cycle.
- `busy` is registered and equals (state != IDLE).
- PAYLOAD state has a combinational `tready`/`tvalid` path; no extra latency.

## Configuration
- `ETH_TX_VLAN_EN` defined:
  - HLEN=18; the 4-byte tag 0x8100+TCI is inserted between src MAC and EtherType.
  - `hdr_vlan_tci` is latched with the other header fields.
- `ETH_TX_VLAN_EN` undefined:
  - HLEN=14; `hdr_vlan_tci` is unused.
  - No tag bytes are ever emitted.

## Test plan
- **Basic frame.** dst=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, type=0x0800, payload 46 bytes 0x00..0x2D, `tready`=1.
  - Expect 60 beats: FF×6, 02 00 00 00 00 01, 08 00, 00..2D.
  - `tlast` on beat 60 only; `frame_count`=1.
- **Backpressure.** Same frame with `m_axis_tready` toggling 1,0,1,0.
  - Output byte sequence is identical to the basic frame.
  - `tdata` is stable on every stalled cycle; no payload byte is lost or duplicated.
- **VLAN (macro defined).** TCI=0x0064, type=0x86DD, 1-byte payload 0xAA.
  - Bytes 12..17 = 81 00 00 64 86 DD, byte 18 = AA with `tlast`.
- **Bad frame and back-to-back.** Frame 1 payload ends with `tuser`=1; frame 2's header is asserted continuously.
  - `m_axis_tuser`=1 on frame 1's last beat.
  - Frame 2's first dst byte appears 2 cycles after frame 1's `tlast` beat.
  - `frame_count`=2.
- **Reset mid-payload.** Assert `rst_n`=0 during payload byte 5.
  - Same cycle: `m_axis_tvalid`=0, `hdr_ready`=1, `frame_count`=0.
  - After release, a new frame transmits correctly from byte 0.
- **Counter wrap.** With `MAX_FRAMES_W`=2, send 5 frames → `frame_count` goes 1,2,3,0,1.
